// File: rtl/character_rom_pkg.sv
`default_nettype none
// ============================================================================
// Module      : character_rom_pkg
// Description : Shared character-ROM glyph indices and a helper that sizes
//               a BCD register for a given binary width.
// Revision    : 1.0 - initial release
// ============================================================================
package character_rom_pkg;

    // ROM index of glyph '0'; digit d lives at CHAR_DIGIT_BASE + d
    localparam int CHAR_DIGIT_BASE = 16;
    localparam int CHAR_BLANK      = 0;
    localparam int CHAR_MINUS      = 13;
    localparam int CHAR_OVERFLOW   = 31;

    // Number of decimal digits needed to hold 2^bits - 1
    function automatic int bcd_digit_count(input int bits);
        longint unsigned max_value;
        int              count;
        max_value = (64'd1 << bits) - 64'd1;
        count     = 1;
        for (int i = 0; i < 20; i++) begin
            if (max_value >= 64'd10) begin
                max_value = max_value / 64'd10;
                count++;
            end
        end
        return count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/binary_to_bcd_serial.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_bcd_serial
// Description : Iterative double-dabble binary-to-BCD converter.
//               Ports: clock, reset (sync, active-high), start (load binary),
//               binary (unsigned input), done (one-cycle pulse, bcd valid
//               from that cycle until the next start), bcd (packed digits,
//               nibble 0 = units).
// Revision    : 1.0 - initial release
// ============================================================================
module binary_to_bcd_serial
    import character_rom_pkg::*;
#(
    parameter  int VALUE_BITS = 12,
    localparam int BCD_DIGITS = bcd_digit_count(VALUE_BITS),
    localparam int BCD_BITS   = 4 * BCD_DIGITS
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  start,
    input  wire logic [VALUE_BITS-1:0] binary,
    output logic                       done,
    output logic [BCD_BITS-1:0]        bcd
);

    localparam int CNT_W = $clog2(VALUE_BITS + 1);

    logic [VALUE_BITS-1:0] r_shift;
    logic [BCD_BITS-1:0]   r_bcd;
    logic [CNT_W-1:0]      r_count;
    logic                  r_busy;
    logic                  r_done;
    logic [BCD_BITS-1:0]   w_adjusted;

    // Add 3 to every nibble >= 5 ahead of the shift
    always_comb begin
        w_adjusted = r_bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adjusted[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // The first iteration is folded into the load: with an all-zero BCD
    // register the adjust step is a no-op, so only the MSB shift remains.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_bcd   <= BCD_BITS'(binary[VALUE_BITS-1]);
                r_shift <= binary << 1;
                r_count <= CNT_W'(1);
                r_busy  <= 1'b1;
            end else if (r_busy) begin
                r_bcd   <= {w_adjusted[BCD_BITS-2:0], r_shift[VALUE_BITS-1]};
                r_shift <= r_shift << 1;
                r_count <= r_count + CNT_W'(1);
                if (r_count == CNT_W'(VALUE_BITS - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/number_to_character_codes.sv
`default_nettype none
// ============================================================================
// Module      : number_to_character_codes
// Description : Converts an unsigned / two's-complement sample into a row of
//               character-ROM select codes with leading-zero blanking, minus
//               sign insertion and overflow flagging.
//               Ports: clock, reset (sync, active-high), start, value,
//               is_signed, blank_leading_zeros (captured on accepted start),
//               busy, done (1-cycle pulse), overflow, characters
//               (slice 0 = rightmost position).
// Revision    : 1.0 - initial release
// ============================================================================
module number_to_character_codes
    import character_rom_pkg::*;
#(
    parameter int VALUE_BITS            = 12,
    parameter int DIGITS                = 4,
    parameter int SELECT_CHARACTER_BITS = 7,
    parameter int DIGIT_BASE            = CHAR_DIGIT_BASE,
    parameter int BLANK_CHARACTER       = CHAR_BLANK,
    parameter int MINUS_CHARACTER       = CHAR_MINUS,
    parameter int OVERFLOW_CHARACTER    = CHAR_OVERFLOW
) (
    input  wire logic                                    clock,
    input  wire logic                                    reset,
    input  wire logic                                    start,
    input  wire logic [VALUE_BITS-1:0]                   value,
    input  wire logic                                    is_signed,
    input  wire logic                                    blank_leading_zeros,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         overflow,
    output logic [DIGITS*SELECT_CHARACTER_BITS-1:0]      characters
);

    localparam int BCD_DIGITS = bcd_digit_count(VALUE_BITS);
    localparam int BCD_BITS   = 4 * BCD_DIGITS;
    // Digits beyond either limit read as zero
    localparam int PAD_DIGITS = (DIGITS > BCD_DIGITS) ? DIGITS : BCD_DIGITS;
    localparam int PAD_BITS   = 4 * PAD_DIGITS;
    localparam int W          = SELECT_CHARACTER_BITS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_FORMAT  = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_negative;
    logic                    r_blank;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_overflow;
    logic [DIGITS*W-1:0]     r_characters;

    logic                    w_accept;
    logic                    w_negative;
    logic [VALUE_BITS-1:0]   w_magnitude;
    logic                    w_core_done;
    logic [BCD_BITS-1:0]     w_core_bcd;
    logic [PAD_BITS-1:0]     w_bcd_pad;
    int                      w_msd;
    logic                    w_high_nonzero;
    logic                    w_overflow;
    logic [W-1:0]            w_code;
    logic [DIGITS*W-1:0]     w_characters;

    assign w_accept    = (r_state == ST_IDLE) && start;
    assign w_negative  = is_signed && value[VALUE_BITS-1];
    // The most negative value negates to itself, which is the correct
    // unsigned magnitude 2^(VALUE_BITS-1).
    assign w_magnitude = w_negative ? (~value + VALUE_BITS'(1)) : value;

    binary_to_bcd_serial #(
        .VALUE_BITS (VALUE_BITS)
    ) u_bcd (
        .clock  (clock),
        .reset  (reset),
        .start  (w_accept),
        .binary (w_magnitude),
        .done   (w_core_done),
        .bcd    (w_core_bcd)
    );

    assign w_bcd_pad = PAD_BITS'(w_core_bcd);

    always_comb begin
        w_msd          = 0;
        w_high_nonzero = 1'b0;
        w_code         = '0;
        w_characters   = '0;
        for (int i = 0; i < PAD_DIGITS; i++) begin
            if (w_bcd_pad[4*i +: 4] != 4'd0) begin
                w_msd = i;
            end
        end
        for (int i = DIGITS; i < PAD_DIGITS; i++) begin
            if (w_bcd_pad[4*i +: 4] != 4'd0) begin
                w_high_nonzero = 1'b1;
            end
        end
        // A negative number needs a free position for the minus sign: with
        // or without blanking this reduces to the top position being zero.
        w_overflow = w_high_nonzero ||
                     (r_negative && (w_bcd_pad[4*(DIGITS-1) +: 4] != 4'd0));
        for (int i = 0; i < DIGITS; i++) begin
            w_code = W'(DIGIT_BASE) + W'(w_bcd_pad[4*i +: 4]);
            if (r_blank) begin
                if (i > w_msd) begin
                    w_code = W'(BLANK_CHARACTER);
                end
                if (r_negative && (i == w_msd + 1)) begin
                    w_code = W'(MINUS_CHARACTER);
                end
            end else if (r_negative && (i == DIGITS - 1)) begin
                w_code = W'(MINUS_CHARACTER);
            end
            if (w_overflow) begin
                w_code = W'(OVERFLOW_CHARACTER);
            end
            w_characters[i*W +: W] = w_code;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_negative   <= 1'b0;
            r_blank      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_characters <= {DIGITS{W'(BLANK_CHARACTER)}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_negative <= w_negative;
                        r_blank    <= blank_leading_zeros;
                        r_busy     <= 1'b1;
                        r_state    <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (w_core_done) begin
                        r_state <= ST_FORMAT;
                    end
                end
                ST_FORMAT: begin
                    r_characters <= w_characters;
                    r_overflow   <= w_overflow;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign characters = r_characters;

endmodule
`default_nettype wire

// File: tb/tb_number_to_character_codes.sv
`default_nettype none
// ============================================================================
// Module      : tb_number_to_character_codes
// Description : Self-checking bench: directed cases plus random values
//               compared against a decimal-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_number_to_character_codes;

    localparam int VB = 12;
    localparam int ND = 4;
    localparam int CW = 7;

    logic             clk;
    logic             rst;
    logic             start;
    logic [VB-1:0]    value;
    logic             is_signed;
    logic             blank_leading_zeros;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [ND*CW-1:0] characters;

    int n_compared;
    int n_mismatched;

    number_to_character_codes u_dut (
        .clock               (clk),
        .reset               (rst),
        .start               (start),
        .value               (value),
        .is_signed           (is_signed),
        .blank_leading_zeros (blank_leading_zeros),
        .busy                (busy),
        .done                (done),
        .overflow            (overflow),
        .characters          (characters)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: decimal digits by division, then the display rules.
    function automatic void model(input logic [VB-1:0] v, input logic s, input logic b,
                                  output logic [ND*CW-1:0] ch, output logic ov);
        int  mag;
        int  d [ND];
        int  ndig;
        int  code;
        bit  neg;
        neg  = s && v[VB-1];
        mag  = neg ? (4096 - int'(v)) : int'(v);
        ndig = (mag >= 1000) ? 4 : (mag >= 100) ? 3 : (mag >= 10) ? 2 : 1;
        for (int i = 0; i < ND; i++) d[i] = (mag / (10 ** i)) % 10;
        ov = (mag >= 10000) || (neg && (ndig + 1 > ND));
        ch = '0;
        for (int i = 0; i < ND; i++) begin
            if (ov) code = 31;
            else if (!b) code = (neg && i == ND - 1) ? 13 : 16 + d[i];
            else if (i < ndig) code = 16 + d[i];
            else if (neg && i == ndig) code = 13;
            else code = 0;
            ch[i*CW +: CW] = CW'(code);
        end
    endfunction

    // Accept one conversion and wait for its result; returns at #1 after
    // the done edge so the next call starts inside the done cycle.
    task automatic convert(input string tag, input logic [VB-1:0] v, input logic s, input logic b);
        logic [ND*CW-1:0] exp_ch;
        logic             exp_ov;
        int               n;
        model(v, s, b, exp_ch, exp_ov);
        @(negedge clk);
        start = 1'b1; value = v; is_signed = s; blank_leading_zeros = b;
        @(posedge clk); #1;
        start = 1'b0; value = $urandom; is_signed = $urandom; blank_leading_zeros = $urandom;
        check_eq({tag, " busy"}, busy, 1'b1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, " latency"}, n, 13);
        check_eq({tag, " chars"}, characters, exp_ch);
        check_eq({tag, " ovf"}, overflow, exp_ov);
        check_eq({tag, " busy_at_done"}, busy, 1'b0);
    endtask

    initial begin
        int dones;
        n_compared = 0; n_mismatched = 0;
        rst = 1'b1; start = 1'b0; value = '0; is_signed = 1'b0; blank_leading_zeros = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("reset chars", characters, '0);
        check_eq("reset ovf", overflow, 1'b0);
        check_eq("reset busy", busy, 1'b0);
        check_eq("reset done", done, 1'b0);

        convert("u1234", 12'd1234, 1'b0, 1'b0);
        check_eq("u1234 direct", characters, {7'd17, 7'd18, 7'd19, 7'd20});
        convert("u42b", 12'd42, 1'b0, 1'b1);
        check_eq("u42b direct", characters, {7'd0, 7'd0, 7'd20, 7'd18});
        convert("u0b", 12'd0, 1'b0, 1'b1);
        check_eq("u0b direct", characters, {7'd0, 7'd0, 7'd0, 7'd16});
        convert("s-5b", 12'hFFB, 1'b1, 1'b1);
        check_eq("s-5b direct", characters, {7'd0, 7'd0, 7'd13, 7'd21});
        convert("s-5", 12'hFFB, 1'b1, 1'b0);
        check_eq("s-5 direct", characters, {7'd13, 7'd16, 7'd16, 7'd21});
        convert("u4095", 12'd4095, 1'b0, 1'b0);
        check_eq("u4095 direct", characters, {7'd20, 7'd16, 7'd25, 7'd21});
        convert("s-999b", 12'hC19, 1'b1, 1'b1);
        convert("u0", 12'd0, 1'b0, 1'b0);
        convert("s-2048", 12'h800, 1'b1, 1'b0);
        check_eq("s-2048 direct", characters, {4{7'd31}});
        check_eq("s-2048 ovf direct", overflow, 1'b1);
        @(posedge clk); #1;
        check_eq("done one cycle", done, 1'b0);

        // Reset 5 cycles into the conversion aborts it (outputs were all 31)
        @(negedge clk);
        start = 1'b1; value = 12'd777; is_signed = 1'b0; blank_leading_zeros = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_eq("abort busy", busy, 1'b0);
        check_eq("abort chars", characters, '0);
        check_eq("abort ovf", overflow, 1'b0);
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check_eq("abort no done", dones, 0);
        convert("after_abort", 12'd305, 1'b0, 1'b1);

        // A second start mid-conversion is ignored
        @(negedge clk);
        start = 1'b1; value = 12'd86; is_signed = 1'b0; blank_leading_zeros = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; value = 12'd3999; is_signed = 1'b0; blank_leading_zeros = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        dones = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                check_eq("ignore chars", characters, {7'd0, 7'd0, 7'd24, 7'd22});
            end
        end
        check_eq("ignore single done", dones, 1);

        for (int k = 0; k < 40; k++) begin
            convert("rand", VB'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/number_to_character_codes.md
# number_to_character_codes

Multi-cycle converter from a binary sample value (unsigned or two's complement) to a row of character-ROM select codes, one per display position. It replaces the fixed three-digit BCD-to-ROM offset stage with a generalised version: it performs its own binary-to-BCD conversion, blanks leading zeros, inserts a minus sign, and flags overflow. It sits between the measurement/readout logic and the text-overlay character ROM addressing.

## Interface
- VALUE_BITS, 12, width of input value
- DIGITS, 4, number of character positions produced
- SELECT_CHARACTER_BITS, 7, width of one ROM select code
- DIGIT_BASE, 16, ROM index of glyph '0'; digit d maps to DIGIT_BASE+d
- BLANK_CHARACTER, 0, ROM index of space
- MINUS_CHARACTER, 13, ROM index of '-'
- OVERFLOW_CHARACTER, 31, ROM index of '?'

- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request conversion; sampled only when busy=0
- value  in  VALUE_BITS  input; captured on accepted start
- is_signed  in  1  treat value as two's complement; captured with value
- blank_leading_zeros  in  1  captured with value
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse: characters/overflow updated
- overflow  out  1  last result did not fit
- characters  out  DIGITS*SELECT_CHARACTER_BITS  packed codes; slice 0 = rightmost (least significant) position

## Operation
- States: IDLE, CONVERT, FORMAT. IDLE --start--> CONVERT (captures inputs, magnitude = |value| if is_signed and MSB set, else value; bit count = 0). CONVERT runs VALUE_BITS double-dabble iterations (add 3 to any BCD nibble >= 5, then shift in next magnitude bit MSB-first), then -> FORMAT. FORMAT computes outputs in one cycle, pulses done, -> IDLE.
- Internal BCD width: BCD_DIGITS = enough digits for 2^VALUE_BITS - 1 (4 for 12 bits), independent of DIGITS.
- Negative = is_signed and value MSB. Most-negative value has magnitude 2^(VALUE_BITS-1), representable.
- Overflow when any BCD digit at index >= DIGITS is nonzero, or when negative and the digit count needed (no blanking: DIGITS; blanking: position of most significant nonzero digit +1) plus one sign position exceeds DIGITS. Overflow: all positions = OVERFLOW_CHARACTER, overflow=1.
- No blanking: position i = DIGIT_BASE + BCD digit i; if negative, position DIGITS-1 = MINUS_CHARACTER (its digit must be 0, else overflow).
- Blanking: positions above the most significant nonzero digit = BLANK_CHARACTER; position 0 always shows a digit (zero renders as single '0'); if negative, minus occupies the position immediately left of the most significant digit.
- characters and overflow change only on FORMAT edge or reset; held stable otherwise.

## Timing
- Reset: state IDLE, busy=0, done=0, overflow=0, every position = BLANK_CHARACTER. Reset mid-conversion aborts; no done pulse.
- start accepted on edge k (busy=0): busy=1 from edge k. CONVERT edges k+1..k+VALUE_BITS. Edge k+VALUE_BITS+1: outputs updated, done=1, busy=0. Latency = VALUE_BITS+1 cycles from accept to done.
- start while busy=1 ignored (no queueing); start during done cycle is accepted.
- value/is_signed/blank_leading_zeros may change freely after acceptance.

## Structure
- Shared package character_rom_pkg: DIGIT_BASE, BLANK/MINUS/OVERFLOW character constants, function computing BCD digit count from bit width; state enum local to block.
- One sub-module: binary_to_bcd_serial (iterative double-dabble core, start/done, VALUE_BITS parameter); this block adds sign handling, formatting and overflow.

## Test plan (defaults)
- Unsigned 1234, no blanking -> positions 3..0 = 17,18,19,20; done exactly 13 cycles after accepting edge; overflow=0.
- Unsigned 42, blanking -> 0,0,20,18; unsigned 0, blanking -> 0,0,0,16.
- Signed 0xFFB (-5): blanking -> 0,0,13,21; no blanking -> 13,16,16,21.
- Signed 0x800 (-2048) -> all 31, overflow=1; unsigned 4095 -> 20,16,25,21, overflow=0.
- start pulsed again mid-conversion with different value -> ignored, single done with first result.
- reset asserted 5 cycles into CONVERT -> busy=0, all positions 0, no done; next start converts normally.
